// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared Funct3 codes, FSM encoding and access-size helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Any Funct3 code that is not a byte or half variant behaves as a word access.
    function automatic lsu_size_e access_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_BYTE, F3_BYTEU: sz = SZ_BYTE;
            F3_HALF, F3_HALFU: sz = SZ_HALF;
            default:           sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr);
        logic mis;
        case (access_size(f3))
            SZ_HALF: mis = addr[0];
            SZ_WORD: mis = (addr != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_format.sv
// rtl/load_format.sv - selects the addressed lane of a bus word and sign/zero extends it
module load_format
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the byte/half lane the address points at, then extend per Funct3.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        result_o  = word_i;
        case (addr_i)
            2'd0:    byte_lane = word_i[7:0];
            2'd1:    byte_lane = word_i[15:8];
            2'd2:    byte_lane = word_i[23:16];
            default: byte_lane = word_i[31:24];
        endcase
        half_lane = addr_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_BYTE:  result_o = {{24{byte_lane[7]}}, byte_lane};
            F3_BYTEU: result_o = {24'h000000, byte_lane};
            F3_HALF:  result_o = {{16{half_lane[15]}}, half_lane};
            F3_HALFU: result_o = {16'h0000, half_lane};
            default:  result_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - stalls the datapath while one load/store runs on a req/ack memory bus
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignedErr,
    output logic        BusErr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusBe,
    input  logic [31:0] BusRData,
    input  logic        BusAck
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [31:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       read_data_q;
    logic              bus_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        lane_q;
    logic [2:0]        f3_q;

    logic              req_any;
    logic              misaligned;
    logic              launch;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       load_result;

    assign req_any    = MemRead | MemWrite;
    assign misaligned = is_misaligned(Funct3, ALUResult[1:0]);
    assign launch     = (state_q == IDLE) && req_any && !misaligned;

    // Stall must rise in the request cycle itself so the PC never advances past the access.
    assign Stall         = launch || (state_q == ACCESS);
    assign MisalignedErr = (state_q == IDLE) && req_any && misaligned;

    assign ReadData = read_data_q;
    assign BusErr   = bus_err_q;
    assign BusReq   = bus_req_q;
    assign BusWe    = bus_we_q;
    assign BusAddr  = bus_addr_q;
    assign BusWData = bus_wdata_q;
    assign BusBe    = bus_be_q;

    // Byte enables and lane-replicated store data; loads always fetch the full word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteData;
        if (MemWrite) begin
            case (access_size(Funct3))
                SZ_BYTE: begin
                    be_d    = 4'b0001 << ALUResult[1:0];
                    wdata_d = {4{WriteData[7:0]}};
                end
                SZ_HALF: begin
                    be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{WriteData[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = WriteData;
                end
            endcase
        end
    end

    load_format u_load_format (
        .word_i   (BusRData),
        .addr_i   (lane_q),
        .funct3_i (f3_q),
        .result_o (load_result)
    );

    // Access FSM: launch from IDLE, hold the bus in ACCESS until ack or timeout, one DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            read_data_q <= 32'h0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
            lane_q      <= 2'b00;
            f3_q        <= 3'b000;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q     <= ACCESS;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= MemWrite;
                        bus_addr_q  <= {ALUResult[31:2], 2'b00};
                        bus_be_q    <= be_d;
                        bus_wdata_q <= wdata_d;
                        lane_q      <= ALUResult[1:0];
                        f3_q        <= Funct3;
                        cnt_q       <= '0;
                    end
                end
                ACCESS: begin
                    // An ack in the expiry cycle wins over the timeout.
                    if (BusAck) begin
                        bus_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (!bus_we_q) begin
                            read_data_q <= load_result;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        bus_req_q   <= 1'b0;
                        bus_err_q   <= 1'b1;
                        read_data_q <= 32'h0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of ACCESS cycles to wait for BusAck before aborting.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port MemRead  input  1  the datapath requests a load.
REQ-005 SHALL have port MemWrite  input  1  the datapath requests a store.
REQ-006 SHALL have port Funct3  input  3  access size and sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-007 SHALL have port ALUResult  input  32  effective byte address.
REQ-008 SHALL have port WriteData  input  32  store data, right-aligned.
REQ-009 SHALL have port ReadData  output  32  formatted, extended load result (registered).
REQ-010 SHALL have port Stall  output  1  freezes PC and register-file write while high.
REQ-011 SHALL have port MisalignedErr  output  1  the current access is misaligned (combinational).
REQ-012 SHALL have port BusErr  output  1  one-cycle pulse on bus timeout.
REQ-013 SHALL have ports BusReq  output  1, BusWe  output  1, BusAddr  output  32 (word-aligned), BusWData  output  32, BusBe  output  4, BusRData  input  32, BusAck  input  1: the memory bus.

Function
REQ-014 SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-015 In IDLE with (MemRead|MemWrite) and aligned: Stall=1 combinationally; next state ACCESS; BusReq, BusWe (=MemWrite), BusAddr={ALUResult[31:2],2'b00}, BusBe and BusWData SHALL be registered.
REQ-016 MemWrite SHALL take priority when MemRead and MemWrite are both high.
REQ-017 Misalignment SHALL be: half with addr[0]=1, or word with addr[1:0]!=0; in IDLE this gives MisalignedErr=1, Stall=0, no bus request, ReadData unchanged.
REQ-018 Unlisted Funct3 codes SHALL be treated as word accesses.
REQ-019 Byte enables: sb gives 1<<addr[1:0]; sh gives 0011 (addr[1]=0) or 1100; sw and all loads give 1111.
REQ-020 BusWData: sb is the byte replicated x4; sh is the halfword replicated x2; sw is WriteData unchanged.
REQ-021 In ACCESS, Stall SHALL be 1 and all bus outputs SHALL be held stable until BusAck is sampled high.
REQ-022 On BusAck in ACCESS: BusReq SHALL drop next cycle; a load SHALL register the lane selected by addr[1:0], sign- or zero-extended per Funct3, into ReadData; next state DONE.
REQ-023 The timeout counter SHALL clear on entry to ACCESS; if TIMEOUT cycles elapse without BusAck: drop BusReq, pulse BusErr one cycle, ReadData=0, next state DONE.
REQ-024 BusAck in the same cycle as timeout expiry SHALL count as success.
REQ-025 DONE: Stall=0 for exactly one cycle; next state IDLE unconditionally; the held MemRead/MemWrite SHALL NOT relaunch a request.
REQ-026 Minimum latency: ack in the first ACCESS cycle gives Stall high for 2 cycles, and ReadData is valid in DONE.
REQ-027 BusAck outside ACCESS SHALL be ignored.

Reset
REQ-028 On reset, asynchronously: state IDLE, BusReq=0, BusWe=0, BusAddr=0, BusWData=0, BusBe=0, ReadData=0, BusErr=0, counter=0.
REQ-029 Reset during ACCESS SHALL drop BusReq immediately; no write completes from the unit's side.

Structure
REQ-030 A shared package lsu_pkg SHALL hold the Funct3 size constants, the state encoding and the TIMEOUT default.
REQ-031 Load lane select and extension SHALL be a combinational sub-module load_format (inputs: word, addr[1:0], Funct3; output: 32-bit result).

Verification
REQ-032 The bench SHALL cover lw at 0x100, BusRData=0xDEADBEEF, ack in the first ACCESS cycle -> Stall high 2 cycles, ReadData=0xDEADBEEF in DONE, BusBe=1111.
REQ-033 The bench SHALL cover lb at 0x103, BusRData=0x80123456 -> ReadData=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-034 The bench SHALL cover sh at 0x102, WriteData=0x0000ABCD -> BusAddr=0x100, BusBe=1100, BusWData=0xABCDABCD, BusWe=1.
REQ-035 The bench SHALL cover lw at 0x101 -> MisalignedErr=1, Stall=0, BusReq never asserted.
REQ-036 The bench SHALL cover lw with BusAck never asserted, TIMEOUT=15 -> BusErr pulses after 15 ACCESS cycles, ReadData=0, Stall falls in DONE.
REQ-037 The bench SHALL cover reset asserted mid-ACCESS -> BusReq=0 and state IDLE in the same cycle; a new lw afterward completes normally.
